// File: rtl/mc_main_controller_if.sv
// Control bus between the multicycle main controller and the datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface mc_main_controller_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       Illegal;
    logic       MemFault;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUop, PCSrc, PCEn, Illegal, MemFault, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUop, PCSrc, PCEn, Illegal, MemFault, State
    );
endinterface

// File: rtl/mc_main_controller.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing,
// MemReady handshake with timeout, sticky HALT trap. Optional macro BNE_EN adds bne.
module mc_main_controller #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_main_controller_if.master bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CMP_W = CNT_W + 1;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
        S_BNEEX   = 4'd12, S_HALT    = 4'd15
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal, r_memfault;
    logic             w_ill_set, w_mf_set, w_cnt_hit, w_waiting, w_in_fetch, w_pcwrite;
    logic             w_op_lw, w_op_sw, w_op_r, w_op_beq, w_op_addi, w_op_j, w_branch_ne;

    logic       r_iord, r_memwrite, r_regdst, r_memtoreg, r_regwrite, r_alusrca, r_pcwrite, r_branch;
    logic [1:0] r_alusrcb, r_aluop, r_pcsrc;
    logic       w_iord, w_memwrite, w_regdst, w_memtoreg, w_regwrite, w_alusrca, w_pcwr, w_branch;
    logic [1:0] w_alusrcb, w_aluop, w_pcsrc;

    assign w_op_lw   = (bus.Op == 6'b100011);
    assign w_op_sw   = (bus.Op == 6'b101011);
    assign w_op_r    = (bus.Op == 6'b000000);
    assign w_op_beq  = (bus.Op == 6'b000100);
    assign w_op_addi = (bus.Op == 6'b001000);
    assign w_op_j    = (bus.Op == 6'b000010);

    assign w_in_fetch = (r_state == S_FETCH);
    assign w_waiting  = w_in_fetch || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Timeout fires on the WAIT_LIMIT-th consecutive cycle without MemReady
    assign w_cnt_hit  = (WAIT_LIMIT != 0) &&
                        ((CMP_W'(r_cnt) + CMP_W'(1)) == CMP_W'(WAIT_LIMIT));

    // Next-state logic
    always_comb begin
        w_next    = r_state;
        w_ill_set = 1'b0;
        w_mf_set  = 1'b0;
        case (r_state)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (bus.MemReady) begin
                    if (r_state == S_FETCH)      w_next = S_DECODE;
                    else if (r_state == S_MEMRD) w_next = S_MEMWB;
                    else                         w_next = S_FETCH;
                end else if (w_cnt_hit) begin
                    w_next   = S_HALT;
                    w_mf_set = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_op_lw || w_op_sw) w_next = S_MEMADR;
                else if (w_op_r)        w_next = S_RTYPEEX;
                else if (w_op_beq)      w_next = S_BEQEX;
                else if (w_op_addi)     w_next = S_ADDIEX;
                else if (w_op_j)        w_next = S_JEX;
`ifdef BNE_EN
                else if (bus.Op == 6'b000101) w_next = S_BNEEX;
`endif
                else begin
                    w_next    = S_HALT;
                    w_ill_set = 1'b1;
                end
            end
            S_MEMADR: begin
                if (w_op_lw)      w_next = S_MEMRD;
                else if (w_op_sw) w_next = S_MEMWR;
                else begin
                    w_next    = S_HALT;
                    w_ill_set = 1'b1;
                end
            end
            S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: w_next = S_FETCH;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
`ifdef BNE_EN
            S_BNEEX:   w_next = S_FETCH;
`endif
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_HALT;
        endcase
    end

    // Moore control decode of the state being entered, registered with the state
    always_comb begin
        w_iord = 1'b0; w_memwrite = 1'b0; w_regdst = 1'b0; w_memtoreg = 1'b0;
        w_regwrite = 1'b0; w_alusrca = 1'b0; w_pcwr = 1'b0; w_branch = 1'b0;
        w_alusrcb = 2'b00; w_aluop = 2'b00; w_pcsrc = 2'b00;
        case (w_next)
            S_FETCH:   w_alusrcb = 2'b01;
            S_DECODE:  w_alusrcb = 2'b11;
            S_MEMADR:  begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
            S_MEMRD:   w_iord = 1'b1;
            S_MEMWB:   begin w_memtoreg = 1'b1; w_regwrite = 1'b1; end
            S_MEMWR:   begin w_iord = 1'b1; w_memwrite = 1'b1; end
            S_RTYPEEX: begin w_alusrca = 1'b1; w_aluop = 2'b10; end
            S_RTYPEWB: begin w_regdst = 1'b1; w_regwrite = 1'b1; end
            S_BEQEX, S_BNEEX: begin
                w_alusrca = 1'b1; w_aluop = 2'b01; w_pcsrc = 2'b01; w_branch = 1'b1;
            end
            S_ADDIEX:  begin w_alusrca = 1'b1; w_alusrcb = 2'b10; end
            S_ADDIWB:  w_regwrite = 1'b1;
            S_JEX:     begin w_pcsrc = 2'b10; w_pcwr = 1'b1; end
            default:   ;
        endcase
    end

`ifdef BNE_EN
    logic r_branch_ne;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_branch_ne <= 1'b0;
        else       r_branch_ne <= (w_next == S_BNEEX);
    end
    assign w_branch_ne = r_branch_ne;
`else
    assign w_branch_ne = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_illegal  <= 1'b0;
            r_memfault <= 1'b0;
            r_iord     <= 1'b0; r_memwrite <= 1'b0; r_regdst <= 1'b0; r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0; r_alusrca  <= 1'b0; r_pcwrite <= 1'b0; r_branch  <= 1'b0;
            r_alusrcb  <= 2'b01; r_aluop   <= 2'b00; r_pcsrc  <= 2'b00;
        end else begin
            r_state    <= w_next;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_waiting && !bus.MemReady && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            r_illegal  <= r_illegal  | w_ill_set;
            r_memfault <= r_memfault | w_mf_set;
            r_iord     <= w_iord;     r_memwrite <= w_memwrite; r_regdst  <= w_regdst;
            r_memtoreg <= w_memtoreg; r_regwrite <= w_regwrite; r_alusrca <= w_alusrca;
            r_pcwrite  <= w_pcwr;     r_branch   <= w_branch;
            r_alusrcb  <= w_alusrcb;  r_aluop    <= w_aluop;    r_pcsrc   <= w_pcsrc;
        end
    end

    // Fetch writes PC and IR together when the instruction word arrives
    assign w_pcwrite = r_pcwrite | (w_in_fetch & bus.MemReady);

    assign bus.IorD     = r_iord     & ~reset;
    assign bus.MemWrite = r_memwrite & ~reset;
    assign bus.IRWrite  = w_in_fetch & bus.MemReady & ~reset;
    assign bus.RegDst   = r_regdst   & ~reset;
    assign bus.MemtoReg = r_memtoreg & ~reset;
    assign bus.RegWrite = r_regwrite & ~reset;
    assign bus.ALUSrcA  = r_alusrca  & ~reset;
    assign bus.ALUSrcB  = reset ? 2'b00 : r_alusrcb;
    assign bus.ALUop    = reset ? 2'b00 : r_aluop;
    assign bus.PCSrc    = reset ? 2'b00 : r_pcsrc;
    assign bus.PCEn     = ~reset & (w_pcwrite | (r_branch & (bus.Zero ^ w_branch_ne)));
    assign bus.Illegal  = r_illegal  & ~reset;
    assign bus.MemFault = r_memfault & ~reset;
    assign bus.State    = r_state;
endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller with WAIT_LIMIT=4; expected control
// vectors are queued as stimulus is applied and checked at the falling edge.
module tb_mc_main_controller;
    localparam int unsigned WL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mc_main_controller_if bus ();

    mc_main_controller #(.WAIT_LIMIT(WL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_ill = 1'b0;
    logic exp_mf  = 1'b0;

    // Reference control table: {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    // RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc, PCEn, Illegal, MemFault}
    function automatic logic [19:0] model(input int st, input logic mr, input logic z,
                                          input logic ill, input logic mf, input logic rst);
        logic iord, mw, irw, rd, m2r, rw, asa, pcen;
        logic [1:0] asb, aop, pcs;
        iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pcen = 0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:  begin asb = 2'b01; irw = mr; pcen = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcen = 1; end
            12: begin asa = 1; aop = 2'b01; pcs = 2'b01; pcen = ~z; end
            default: ;
        endcase
        if (rst) return {4'(st), 16'h0000};
        return {4'(st), iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcen, ill, mf};
    endfunction

    task automatic chk(input string tag, input int st);
        exp_t        e;
        logic [19:0] obs;
        e.tag = tag;
        e.v   = model(st, bus.MemReady, bus.Zero, exp_ill, exp_mf, reset);
        sb.push_back(e);
        @(negedge clk);
        e   = sb.pop_front();
        obs = {bus.State, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
               bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUop, bus.PCSrc, bus.PCEn,
               bus.Illegal, bus.MemFault};
        n_vec++;
        assert (obs === e.v) else begin
            n_err++;
            $error("FAIL %s: observed %05h expected %05h", e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.Op = 6'b000000; bus.Zero = 1'b0; bus.MemReady = 1'b1;
        @(posedge clk); #1;
        chk("reset_forced_zero", 0);
        reset = 1'b0;

        bus.Op = 6'b100011;
        chk("lw_fetch", 0); chk("lw_decode", 1); chk("lw_memadr", 2);
        chk("lw_memrd", 3); chk("lw_memwb", 4);

        bus.Op = 6'b101011;
        chk("sw_fetch", 0); chk("sw_decode", 1); chk("sw_memadr", 2);
        bus.MemReady = 1'b0;
        chk("sw_wait0", 5); chk("sw_wait1", 5); chk("sw_wait2", 5);
        bus.MemReady = 1'b1;
        chk("sw_done", 5);

        bus.Op = 6'b000100; bus.Zero = 1'b1;
        chk("beq_t_fetch", 0); chk("beq_t_decode", 1); chk("beq_taken", 8);
        bus.Zero = 1'b0;
        chk("beq_n_fetch", 0); chk("beq_n_decode", 1); chk("beq_not_taken", 8);

        bus.Op = 6'b000000;
        chk("r_fetch", 0); chk("r_decode", 1); chk("r_ex", 6); chk("r_wb", 7);
        bus.Op = 6'b000010;
        chk("j_fetch", 0); chk("j_decode", 1); chk("j_ex", 11);

        bus.Op = 6'b100011;
        chk("lws_fetch", 0); chk("lws_decode", 1); chk("lws_memadr", 2);
        bus.MemReady = 1'b0;
        chk("lws_wait0", 3); chk("lws_wait1", 3);
        bus.MemReady = 1'b1;
        chk("lws_memrd", 3); chk("lws_memwb", 4);

        bus.Op = 6'b001000;
        chk("addi_fetch", 0); chk("addi_decode", 1); chk("addi_ex", 9); chk("addi_wb", 10);

        bus.Op = 6'b000000;
        chk("mid_fetch", 0); chk("mid_decode", 1); chk("mid_ex", 6);
        reset = 1'b1;
        chk("mid_reset", 0);
        reset = 1'b0;
        chk("post_reset_fetch", 0); chk("post_reset_decode", 1);
        chk("post_reset_ex", 6); chk("post_reset_wb", 7);

        bus.MemReady = 1'b0;
        for (int i = 0; i < 4; i++) chk("timeout_wait", 0);
        exp_mf = 1'b1;
        chk("timeout_halt", 15);
        bus.MemReady = 1'b1;
        chk("timeout_halt_held", 15);
        reset = 1'b1; exp_mf = 1'b0;
        chk("timeout_reset", 0);
        reset = 1'b0;

        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) chk("limit_wait", 0);
        bus.MemReady = 1'b1;
        chk("limit_ready_wins", 0);
        chk("limit_decode", 1); chk("limit_ex", 6); chk("limit_wb", 7);

        bus.Op = 6'b000101; bus.Zero = 1'b0;
        chk("bne_fetch", 0); chk("bne_decode", 1);
`ifdef BNE_EN
        chk("bne_taken", 12);
        bus.Zero = 1'b1;
        chk("bne_n_fetch", 0); chk("bne_n_decode", 1); chk("bne_not_taken", 12);
`else
        exp_ill = 1'b1;
        chk("bne_illegal", 15);
        reset = 1'b1; exp_ill = 1'b0;
        chk("bne_reset", 0);
        reset = 1'b0;
`endif

        bus.Op = 6'b111111;
        chk("ill_fetch", 0); chk("ill_decode", 1);
        exp_ill = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.MemReady = i[0];
            bus.Zero     = i[1];
            chk("ill_halt", 15);
        end
        reset = 1'b1; exp_ill = 1'b0;
        chk("ill_reset", 0);
        reset = 1'b0; bus.MemReady = 1'b1; bus.Op = 6'b000000;
        chk("ill_post_fetch", 0); chk("ill_post_decode", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
